// File: rtl/debounce_pkg.sv
// Shared types and helpers for the data_debounce block.
package debounce_pkg;

    // Filter FSM states; encoding is fixed so bit 0 marks the two wait states.
    typedef enum logic [1:0] {
        LOW       = 2'b00,
        RISE_WAIT = 2'b01,
        HIGH      = 2'b10,
        FALL_WAIT = 2'b11
    } state_t;

    localparam int unsigned DEFAULT_STABLE_CYCLES = 4;
    localparam int unsigned SYNC_STAGES           = 2;

    // True while the filter is qualifying a candidate level.
    function automatic logic is_wait(state_t s);
        return (s == RISE_WAIT) || (s == FALL_WAIT);
    endfunction

endpackage

// File: rtl/data_debounce_if.sv
// Source bit and conditioned outputs of the debouncer, grouped as one bundle.
interface data_debounce_if;
    logic data_in;
    logic data_out;
    logic rise_pulse;
    logic fall_pulse;
    logic busy;

    // Producer of the raw bit / consumer of the debounced results.
    modport master (
        output data_in,
        input  data_out,
        input  rise_pulse,
        input  fall_pulse,
        input  busy
    );

    // The debouncer itself.
    modport slave (
        input  data_in,
        output data_out,
        output rise_pulse,
        output fall_pulse,
        output busy
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, synchronous active-low reset.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic r_meta;
    logic r_sync;

    // Double-register the input; both stages clear to 0 on reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;
endmodule

// File: rtl/data_debounce.sv
// Debounces a noisy single-bit source into a clean level with commit pulses.
// Optional build macro DEBOUNCE_SYNC_EN inserts a 2-flop synchronizer ahead of
// the filter (latency STABLE_CYCLES+2); without it data_in must already be
// synchronous to clk (latency STABLE_CYCLES).
module data_debounce
    import debounce_pkg::*;
#(
    parameter  int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    localparam int unsigned CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic            clk,
    input  logic            reset,
    data_debounce_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             w_s;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_data_out;
    logic             r_rise;
    logic             r_fall;
    logic             r_busy;

`ifdef DEBOUNCE_SYNC_EN
    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.data_in),
        .q     (w_s)
    );
`else
    assign w_s = bus.data_in;
`endif

    // Filter FSM: a new level commits only after STABLE_CYCLES equal samples.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= LOW;
            r_cnt      <= '0;
            r_data_out <= 1'b0;
            r_rise     <= 1'b0;
            r_fall     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                LOW: begin
                    if (w_s) begin
                        r_state <= RISE_WAIT;
                        r_cnt   <= CNT_ONE;
                        r_busy  <= 1'b1;
                    end
                end
                RISE_WAIT: begin
                    if (!w_s) begin
                        r_state <= LOW;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state    <= HIGH;
                        r_cnt      <= '0;
                        r_data_out <= 1'b1;
                        r_rise     <= 1'b1;
                        r_busy     <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                HIGH: begin
                    if (!w_s) begin
                        r_state <= FALL_WAIT;
                        r_cnt   <= CNT_ONE;
                        r_busy  <= 1'b1;
                    end
                end
                FALL_WAIT: begin
                    if (w_s) begin
                        r_state <= HIGH;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state    <= LOW;
                        r_cnt      <= '0;
                        r_data_out <= 1'b0;
                        r_fall     <= 1'b1;
                        r_busy     <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= LOW;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out   = r_data_out;
    assign bus.rise_pulse = r_rise;
    assign bus.fall_pulse = r_fall;
    assign bus.busy       = r_busy;
endmodule

// File: tb/tb_data_debounce.sv
// Self-checking bench for data_debounce: run-length reference model plus directed cases.
module tb_data_debounce;
    localparam int SC = 4;
`ifdef DEBOUNCE_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif
    localparam int LAT = SC + SYNC;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    data_debounce_if bus();

    data_debounce #(.STABLE_CYCLES(SC)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: s is data_in delayed by the synchronizer depth; the output flips
    // once s has differed from it for SC consecutive samples.
    logic m_d1 = 1'b0, m_d2 = 1'b0;
    logic m_out = 1'b0, m_rise = 1'b0, m_fall = 1'b0, m_busy = 1'b0;
    int   m_run = 0;
    bit   m_valid = 1'b0;

    always @(posedge clk) begin
        logic s;
        int   run;
        if (!reset) begin
            m_d1 <= 1'b0; m_d2 <= 1'b0;
            m_out <= 1'b0; m_rise <= 1'b0; m_fall <= 1'b0; m_busy <= 1'b0;
            m_run <= 0;
            m_valid <= 1'b1;
        end else begin
`ifdef DEBOUNCE_SYNC_EN
            s = m_d2;
`else
            s = bus.data_in;
`endif
            m_d1 <= bus.data_in;
            m_d2 <= m_d1;
            run = (s != m_out) ? m_run + 1 : 0;
            m_rise <= 1'b0;
            m_fall <= 1'b0;
            if (run == SC) begin
                m_out  <= s;
                m_rise <= s;
                m_fall <= ~s;
                run = 0;
            end
            m_run  <= run;
            m_busy <= (run != 0);
        end
    end

    // Every-cycle comparison against the reference once reset has been seen.
    always @(negedge clk) begin
        if (m_valid) begin
            check("model_data_out",   bus.data_out,   m_out);
            check("model_rise_pulse", bus.rise_pulse, m_rise);
            check("model_fall_pulse", bus.fall_pulse, m_fall);
            check("model_busy",       bus.busy,       m_busy);
        end
    end

    // Count clocks until data_out reaches level; checks latency and pulse shape.
    task automatic measure_edge(input string name, input logic level);
        int k;
        k = 0;
        for (int i = 1; i <= LAT + 8; i++) begin
            @(negedge clk);
            if (bus.data_out == level) begin
                k = i;
                break;
            end
        end
        check({name, "_latency"}, k, LAT);
        if (level) check({name, "_pulse_on"}, bus.rise_pulse, 1);
        else       check({name, "_pulse_on"}, bus.fall_pulse, 1);
        @(negedge clk);
        check({name, "_pulse_width"}, level ? bus.rise_pulse : bus.fall_pulse, 0);
    endtask

    initial begin
        logic saw_busy, saw_pulse, saw_change;
        logic lvl;
        int   len;

        // 1. Reset held with data_in=1.
        reset = 1'b0;
        bus.data_in = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data_out", bus.data_out, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_rise", bus.rise_pulse, 0);

        // 2. Release reset, data_in held high.
        reset = 1'b1;
        measure_edge("rise", 1'b1);

        // 3. Two-cycle low glitch while HIGH.
        bus.data_in = 1'b0;
        saw_busy = 1'b0; saw_pulse = 1'b0; saw_change = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 1) bus.data_in = 1'b1;
            saw_busy   |= bus.busy;
            saw_pulse  |= bus.fall_pulse | bus.rise_pulse;
            saw_change |= ~bus.data_out;
        end
        check("glitch_busy_seen", saw_busy, 1);
        check("glitch_no_pulse", saw_pulse, 0);
        check("glitch_level_kept", saw_change, 0);

        // 4. Sustained low commits a fall.
        bus.data_in = 1'b0;
        measure_edge("fall", 1'b0);

        // 5. Reset in RISE_WAIT with cnt=2, then fresh qualification.
        bus.data_in = 1'b1;
        repeat (LAT - 2) @(negedge clk);
        check("wait_busy_before_reset", bus.busy, 1);
        reset = 1'b0;
        @(negedge clk);
        check("midreset_busy", bus.busy, 0);
        check("midreset_data_out", bus.data_out, 0);
        check("midreset_rise", bus.rise_pulse, 0);
        reset = 1'b1;
        measure_edge("rerise", 1'b1);

        // 6. Toggle every 3 clocks for 50 clocks: nothing may commit.
        saw_pulse = 1'b0; saw_change = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (i % 3 == 0) bus.data_in = ~bus.data_in;
            @(negedge clk);
            saw_pulse  |= bus.fall_pulse | bus.rise_pulse;
            saw_change |= ~bus.data_out;
        end
        check("toggle_no_pulse", saw_pulse, 0);
        check("toggle_level_kept", saw_change, 0);

        // Randomized runs with occasional resets; the model process checks every cycle.
        for (int seg = 0; seg < 300; seg++) begin
            lvl = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 8));
            bus.data_in = lvl;
            for (int c = 0; c < len; c++) begin
                reset = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
                @(negedge clk);
            end
        end
        reset = 1'b1;
        repeat (LAT + 4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
